// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter with an on-chip byte FIFO.
//
// Bytes written through the WR/full handshake are queued in a circular
// buffer and sent LSB first. One start bit, eight data bits and one stop bit
// are sent, and each bit lasts Baudrate Clk cycles. While the FIFO holds data,
// frames go out back-to-back with no idle cycle between them.
//
// Parameters:
//   Baudrate : Clk cycles per serial bit (2..8191)
//   DEPTH    : FIFO depth in bytes (power of two, >= 2)
//
// Ports:
//   Clk     in   rising-edge clock
//   Reset   in   synchronous active-high reset (flushes FIFO, aborts frame)
//   data_in in   byte to queue
//   WR      in   write strobe, accepted when full is low
//   TX      out  registered serial line, idle high
//   busy    out  transmitter not idle
//   full    out  FIFO holds DEPTH bytes
//   empty   out  FIFO holds no bytes
//   count   out  number of queued bytes
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned Baudrate = 2603,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [7:0]               data_in,
    input  logic                     WR,
    output logic                     TX,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [12:0] BAUD_LAST = 13'(Baudrate - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Transmit datapath
    logic [1:0]    state;
    logic [12:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_r;

    logic          tick;
    logic          push;
    logic          pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign busy  = (state != S_IDLE);
    assign TX    = tx_r;

    assign tick = (baud_cnt == BAUD_LAST);
    assign push = WR & ~full;

    // A byte is taken from the FIFO either when leaving IDLE or at the end
    // of a stop bit with more data waiting (back-to-back frame).
    assign pop = ~empty & ((state == S_IDLE) | ((state == S_STOP) & tick));

    // ---------------------------------------------------------------------
    // FIFO: push and pop on the same edge leave the count unchanged.
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once cnt is 0.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM. TX is registered alongside the state so the line changes
    // only on clock edges.
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_r     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    tx_r     <= 1'b1;
                    if (!empty) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        tx_r  <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        tx_r     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            // shift[1] is the bit that becomes shift[0]
                            // after this edge's right shift.
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx_r    <= shift[1];
                        end else begin
                            state <= S_STOP;
                            tx_r  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        if (!empty) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            tx_r  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx_r  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    tx_r     <= 1'b1;
                end
            endcase
        end
    end

endmodule
